// File: rtl/digit_scanner.sv
// Four-digit multiplexed hex display scanner with a one-deep load buffer.
// New values commit only at frame boundaries so a frame never mixes two values.
module digit_scanner #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        blank_lz,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned    PcW   = $clog2(PRESCALE);
    localparam logic [PcW-1:0] PcMax = PcW'(PRESCALE - 1);

    logic [15:0]    shown_q, shown_d;
    logic [15:0]    pending_q, pending_d;
    logic           pend_full_q, pend_full_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [1:0]     idx_q, idx_d;

    logic           slot_end;
    logic           frame_end;
    logic           accept;
    logic           upper_zero;
    logic [3:0]     nibble;

    assign slot_end   = (pc_q == PcMax);
    assign frame_end  = slot_end && (idx_q == 2'd3);
    assign load_ready = ~pend_full_q;
    assign accept     = load_valid && load_ready;
    assign frame_tick = frame_end;

    always_comb begin
        pc_d        = slot_end ? '0 : pc_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        shown_d     = shown_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        // Accept and commit are mutually exclusive: accept needs an empty buffer.
        if (frame_end && pend_full_q) begin
            shown_d     = pending_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pending_d   = value_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_q     <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            pc_q        <= '0;
            idx_q       <= '0;
        end else begin
            shown_q     <= shown_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            pc_q        <= pc_d;
            idx_q       <= idx_d;
        end
    end

    assign nibble       = shown_q[{idx_q, 2'b00} +: 4];
    assign {w, x, y, z} = nibble;

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        upper_zero = 1'b0;
        unique case (idx_q)
            2'd0: upper_zero = 1'b0;
            2'd1: upper_zero = (shown_q[15:4] == '0);
            2'd2: upper_zero = (shown_q[15:8] == '0);
            2'd3: upper_zero = (shown_q[15:12] == '0);
        endcase
        an = 4'b1111;
        if (!(blank_lz && upper_zero)) begin
            an[idx_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Bench for digit_scanner: table-driven display checks, hand-written corner
// sequences and randomized traffic against a time-indexed reference model.
module tb_digit_scanner;

    localparam int unsigned P     = 4;
    localparam int          FRAME = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic        load_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic        load_ready;
    logic        w, x, y, z;
    logic [3:0]  an;
    logic        frame_tick;

    digit_scanner #(.PRESCALE(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .w          (w),
        .x          (x),
        .y          (y),
        .z          (z),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position in the frame is just a cycle count mod 4*P.
    int          t;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    bit          m_full;
    bit          last_ft;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_digit();
        return (t / P) % 4;
    endfunction

    function automatic logic [3:0] m_nib();
        logic [15:0] s;
        s = m_shown >> (4 * m_digit());
        return s[3:0];
    endfunction

    function automatic logic [3:0] m_an();
        int          d;
        logic [15:0] s;
        logic [3:0]  one;
        d   = m_digit();
        s   = m_shown >> (4 * d);
        one = 4'b0001;
        if (blank_lz && d > 0 && s == 16'h0) return 4'hF;
        return ~(one << d);
    endfunction

    function automatic logic [15:0] wxyz();
        return {12'h0, w, x, y, z};
    endfunction

    task automatic model_reset();
        t       = 0;
        m_shown = 16'h0;
        m_pend  = 16'h0;
        m_full  = 1'b0;
    endtask

    task automatic model_step();
        bit fe;
        fe = (t % FRAME) == FRAME - 1;
        if (fe && m_full) begin
            m_shown = m_pend;
            m_full  = 1'b0;
        end else if (load_valid && !m_full) begin
            m_pend = value_in;
            m_full = 1'b1;
        end
        t = (t + 1) % FRAME;
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic tick();
        #1;
        last_ft = frame_tick;
        chk("an", {12'h0, an}, {12'h0, m_an()});
        chk("wxyz", wxyz(), {12'h0, m_nib()});
        chk("load_ready", {15'h0, load_ready}, {15'h0, !m_full});
        chk("frame_tick", {15'h0, frame_tick}, {15'h0, (t % FRAME) == FRAME - 1});
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    // Runs through the next frame_end edge; n is the number of clocks taken.
    task automatic run_to_frame_end(output int n);
        n = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            n++;
            if (last_ft) return;
        end
        chk("frame_tick_timeout", 16'h0, 16'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_an", {12'h0, an}, 16'h000E);
        chk("rst_wxyz", wxyz(), 16'h0);
        chk("rst_load_ready", {15'h0, load_ready}, 16'h1);
        chk("rst_frame_tick", {15'h0, frame_tick}, 16'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [15:0] v);
        for (int i = 0; i < 4 * FRAME && !load_ready; i++) tick();
        value_in   = v;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("ready_drop", {15'h0, load_ready}, 16'h0);
    endtask

    typedef struct {
        logic [15:0] val;
        bit          blank;
        logic [15:0] an_exp;  // an for digit d at [4d+3:4d]
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{val: 16'h1A2F, blank: 1'b0, an_exp: 16'h7BDE};
        vecs[1] = '{val: 16'h0030, blank: 1'b1, an_exp: 16'hFFDE};
        vecs[2] = '{val: 16'h0030, blank: 1'b0, an_exp: 16'h7BDE};
        vecs[3] = '{val: 16'h0000, blank: 1'b1, an_exp: 16'hFFFE};
        vecs[4] = '{val: 16'h0A00, blank: 1'b1, an_exp: 16'hFBDE};
        vecs[5] = '{val: 16'h8000, blank: 1'b1, an_exp: 16'h7BDE};

        model_reset();
        #2;
        do_reset();

        // Idle after reset: frame period is 4*P clocks.
        run_to_frame_end(n);
        chk("first_frame_len", 16'(n), 16'(FRAME));
        run_to_frame_end(n);
        chk("frame_len", 16'(n), 16'(FRAME));

        // Table: load, wait for commit, then walk one frame slot by slot.
        foreach (vecs[k]) begin
            load(vecs[k].val);
            run_to_frame_end(n);
            chk("ready_back", {15'h0, load_ready}, 16'h1);
            blank_lz = vecs[k].blank;
            for (int d = 0; d < 4; d++) begin
                #1;
                chk("tbl_an", {12'h0, an}, {12'h0, vecs[k].an_exp[4*d +: 4]});
                chk("tbl_wxyz", wxyz(), {12'h0, vecs[k].val[4*d +: 4]});
                for (int c = 0; c < int'(P); c++) tick();
            end
        end

        // Blanking follows blank_lz live within a slot.
        load(16'h0030);
        run_to_frame_end(n);
        blank_lz = 1'b1;
        for (int c = 0; c < 2 * int'(P); c++) tick();
        chk("blank_slot2", {12'h0, an}, 16'h000F);
        blank_lz = 1'b0;
        #1;
        chk("unblank_slot2", {12'h0, an}, 16'h000B);

        // Back-to-back offers: the second is ignored while the buffer is full.
        run_to_frame_end(n);
        value_in   = 16'h1111;
        load_valid = 1'b1;
        tick();
        value_in   = 16'h2222;
        tick();
        load_valid = 1'b0;
        chk("b2b_ready", {15'h0, load_ready}, 16'h0);
        run_to_frame_end(n);
        chk("b2b_shown", wxyz(), 16'h1);
        load(16'h2222);
        run_to_frame_end(n);
        chk("reoffer_shown", wxyz(), 16'h2);

        // Accept on the frame_end edge with an empty buffer waits a whole frame.
        for (int i = 0; i < FRAME && t != FRAME - 1; i++) tick();
        value_in   = 16'h3333;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("fe_accept_ready", {15'h0, load_ready}, 16'h0);
        chk("fe_accept_old", wxyz(), 16'h2);
        run_to_frame_end(n);
        chk("fe_accept_new", wxyz(), 16'h3);

        // Reset mid-frame discards the pending value.
        run_to_frame_end(n);
        load(16'h5555);
        for (int i = 0; i < FRAME && m_digit() != 2; i++) tick();
        do_reset();
        run_to_frame_end(n);
        chk("post_rst_wxyz0", wxyz(), 16'h0);
        for (int c = 0; c < FRAME; c++) tick();
        chk("post_rst_ready", {15'h0, load_ready}, 16'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            value_in   = 16'($urandom);
            load_valid = ($urandom_range(0, 3) == 0);
            blank_lz   = 1'($urandom_range(0, 1));
            if (($urandom_range(0, 3) == 0)) value_in[15:8] = 8'h00;
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick();
        end
        load_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
